// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the framebuffer SRAM arbiter.
package sram_arb_pkg;

  // Source tag carried with every outstanding read
  typedef enum logic {
    TAG_DISP = 1'b0,
    TAG_FADE = 1'b1
  } tag_e;

  // Requester indices into the grant vector
  localparam int REQ_DISP = 0;
  localparam int REQ_FADE = 1;
  localparam int REQ_WR   = 2;
  localparam int NUM_REQ  = 3;

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Read-tag FIFO: remembers which requester owns each in-flight read.
// The read port is first-word fall-through so the tag is available in the
// same cycle as the returning data.
module sram_arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  tag_e             i_push_tag,
  input  logic             i_pop,
  output tag_e             o_pop_tag,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_e             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_tag = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Tag storage; contents need no reset because the count gates every use
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_tag;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_xy_arbiter.sv
// Three-way arbiter for the framebuffer SRAM port: display reads have
// priority, fade traffic next, ADC pixel writes last but with a starvation
// bound. Reads are tagged so returning data goes back to its owner in order.
module sram_xy_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      disp_req_valid,
  output logic                      disp_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] disp_req_addr,
  output logic                      disp_resp_valid,
  output logic [AXI_DATA_WIDTH-1:0] disp_resp_data,
  input  logic                      fade_req_valid,
  output logic                      fade_req_ready,
  input  logic                      fade_req_we,
  input  logic [AXI_ADDR_WIDTH-1:0] fade_req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] fade_req_wdata,
  output logic                      fade_resp_valid,
  output logic [AXI_DATA_WIDTH-1:0] fade_resp_data,
  input  logic                      wr_req_valid,
  output logic                      wr_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] wr_req_wdata,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [AXI_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [AXI_DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [AXI_DATA_WIDTH-1:0] mem_resp_data,
  output logic                      resp_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic                      r_rst_q;
  logic                      r_mem_valid;
  logic                      r_mem_we;
  logic [AXI_ADDR_WIDTH-1:0] r_mem_addr;
  logic [AXI_DATA_WIDTH-1:0] r_mem_wdata;
  logic [STV_W-1:0]          r_starve;
  logic                      r_disp_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_disp_rdata;
  logic                      r_fade_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_fade_rdata;
  logic                      r_err;

  logic [NUM_REQ-1:0]        w_grant;
  logic                      w_slot_free;
  logic                      w_read_ok;
  logic                      w_force_wr;
  logic                      w_push;
  tag_e                      w_push_tag;
  logic                      w_pop;
  tag_e                      w_pop_tag;
  logic [CNT_W-1:0]          w_count;
  logic                      w_full;
  logic                      w_empty;

  // Count is the pre-pop value, so a slot freed this cycle is usable next cycle
  assign w_slot_free = !r_mem_valid || mem_req_ready;
  assign w_read_ok   = (w_count < CNT_W'(MAX_OUTSTANDING));
  assign w_force_wr  = wr_req_valid && (r_starve == STV_W'(STARVE_LIMIT));

  // Winner selection; nothing is granted during reset or the cycle after it
  always_comb begin
    w_grant = '0;
    if (!reset && !r_rst_q && w_slot_free) begin
      if (w_force_wr)                                  w_grant[REQ_WR]   = 1'b1;
      else if (disp_req_valid && w_read_ok)            w_grant[REQ_DISP] = 1'b1;
      else if (fade_req_valid && (fade_req_we || w_read_ok)) w_grant[REQ_FADE] = 1'b1;
      else if (wr_req_valid)                           w_grant[REQ_WR]   = 1'b1;
    end
  end

  assign disp_req_ready = w_grant[REQ_DISP];
  assign fade_req_ready = w_grant[REQ_FADE];
  assign wr_req_ready   = w_grant[REQ_WR];

  assign w_push     = (w_grant[REQ_DISP] || (w_grant[REQ_FADE] && !fade_req_we)) && !w_full;
  assign w_push_tag = w_grant[REQ_FADE] ? TAG_FADE : TAG_DISP;
  assign w_pop      = mem_resp_valid && !w_empty;

  sram_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_tag (w_push_tag),
    .i_pop      (w_pop),
    .o_pop_tag  (w_pop_tag),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Delayed reset flag that keeps the readies low for one cycle after release
  always_ff @(posedge clk) begin
    r_rst_q <= reset;
  end

  // Single output slot toward the SRAM controller; holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_slot_free) begin
      r_mem_valid <= |w_grant;
      if (w_grant[REQ_DISP]) begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= disp_req_addr;
        r_mem_wdata <= '0;
      end else if (w_grant[REQ_FADE]) begin
        r_mem_we    <= fade_req_we;
        r_mem_addr  <= fade_req_addr;
        r_mem_wdata <= fade_req_wdata;
      end else if (w_grant[REQ_WR]) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= wr_req_addr;
        r_mem_wdata <= wr_req_wdata;
      end
    end
  end

  // Starvation counter for the pixel writer, saturating at the limit
  always_ff @(posedge clk) begin
    if (reset || !wr_req_valid || wr_req_ready) begin
      r_starve <= '0;
    end else if (r_starve != STV_W'(STARVE_LIMIT)) begin
      r_starve <= r_starve + STV_W'(1);
    end
  end

  // Route returning read data by tag; an untagged response is flagged and dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_rvalid <= 1'b0;
      r_disp_rdata  <= '0;
      r_fade_rvalid <= 1'b0;
      r_fade_rdata  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_disp_rvalid <= w_pop && (w_pop_tag == TAG_DISP);
      r_fade_rvalid <= w_pop && (w_pop_tag == TAG_FADE);
      if (w_pop && (w_pop_tag == TAG_DISP)) r_disp_rdata <= mem_resp_data;
      if (w_pop && (w_pop_tag == TAG_FADE)) r_fade_rdata <= mem_resp_data;
      if (mem_resp_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign mem_req_valid   = r_mem_valid;
  assign mem_req_we      = r_mem_we;
  assign mem_req_addr    = r_mem_addr;
  assign mem_req_wdata   = r_mem_wdata;
  assign disp_resp_valid = r_disp_rvalid;
  assign disp_resp_data  = r_disp_rdata;
  assign fade_resp_valid = r_fade_rvalid;
  assign fade_resp_data  = r_fade_rdata;
  assign resp_err        = r_err;

endmodule

// File: tb/tb_sram_xy_arbiter.sv
// Directed bench for the framebuffer SRAM arbiter.
module tb_sram_xy_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req_valid, disp_req_ready;
  logic [19:0] disp_req_addr;
  logic        disp_resp_valid;
  logic [15:0] disp_resp_data;
  logic        fade_req_valid, fade_req_ready, fade_req_we;
  logic [19:0] fade_req_addr;
  logic [15:0] fade_req_wdata;
  logic        fade_resp_valid;
  logic [15:0] fade_resp_data;
  logic        wr_req_valid, wr_req_ready;
  logic [19:0] wr_req_addr;
  logic [15:0] wr_req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [19:0] mem_req_addr;
  logic [15:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
  logic        resp_err;

  logic        auto_resp;
  int          n_chk = 0;
  int          n_err = 0;

  sram_xy_arbiter #(
    .AXI_ADDR_WIDTH  (20),
    .AXI_DATA_WIDTH  (16),
    .MAX_OUTSTANDING (4),
    .STARVE_LIMIT    (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .disp_req_valid  (disp_req_valid),
    .disp_req_ready  (disp_req_ready),
    .disp_req_addr   (disp_req_addr),
    .disp_resp_valid (disp_resp_valid),
    .disp_resp_data  (disp_resp_data),
    .fade_req_valid  (fade_req_valid),
    .fade_req_ready  (fade_req_ready),
    .fade_req_we     (fade_req_we),
    .fade_req_addr   (fade_req_addr),
    .fade_req_wdata  (fade_req_wdata),
    .fade_resp_valid (fade_resp_valid),
    .fade_resp_data  (fade_resp_data),
    .wr_req_valid    (wr_req_valid),
    .wr_req_ready    (wr_req_ready),
    .wr_req_addr     (wr_req_addr),
    .wr_req_wdata    (wr_req_wdata),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .resp_err        (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the controller model optionally answers a read handshake
  // seen in this cycle with a single-cycle response pulse after the edge.
  task automatic tick();
    logic        rd_hs;
    logic [19:0] a;
    rd_hs = auto_resp && mem_req_valid && mem_req_ready && !mem_req_we;
    a     = mem_req_addr;
    @(posedge clk);
    #1;
    mem_resp_valid = rd_hs;
    mem_resp_data  = rd_hs ? (a[15:0] ^ 16'h5A5A) : 16'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; auto_resp = 1'b0;
    disp_req_valid = 0; disp_req_addr = '0;
    fade_req_valid = 0; fade_req_we = 0; fade_req_addr = '0; fade_req_wdata = '0;
    wr_req_valid = 0; wr_req_addr = '0; wr_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;

    // Reset and the gated cycle after release
    tick(); tick();
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    reset = 1'b0;
    disp_req_valid = 1; disp_req_addr = 20'h00010;
    fade_req_valid = 1; fade_req_we = 0; fade_req_addr = 20'h00020;
    wr_req_valid = 1; wr_req_addr = 20'h00030; wr_req_wdata = 16'hBEEF;
    #1;
    chk("gate_disp_rdy", disp_req_ready, 0);
    chk("gate_fade_rdy", fade_req_ready, 0);
    chk("gate_wr_rdy", wr_req_ready, 0);
    chk("gate_mem_valid", mem_req_valid, 0);
    tick();

    // Priority: disp, fade, wr
    mem_req_ready = 1; #1;
    chk("pri_disp_rdy", disp_req_ready, 1);
    chk("pri_fade_rdy0", fade_req_ready, 0);
    chk("pri_wr_rdy0", wr_req_ready, 0);
    tick(); disp_req_valid = 0; #1;
    chk("pri_mem_disp", {mem_req_valid, mem_req_we, mem_req_addr}, {2'b10, 20'h00010});
    chk("pri_fade_rdy", fade_req_ready, 1);
    chk("pri_wr_rdy1", wr_req_ready, 0);
    tick(); fade_req_valid = 0; #1;
    chk("pri_mem_fade", {mem_req_valid, mem_req_we, mem_req_addr}, {2'b10, 20'h00020});
    chk("pri_wr_rdy", wr_req_ready, 1);
    tick(); wr_req_valid = 0; #1;
    chk("pri_mem_wr", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, {2'b11, 20'h00030, 16'hBEEF});
    chk("pri_none_rdy", {disp_req_ready, fade_req_ready, wr_req_ready}, 0);
    tick(); #1;
    chk("pri_slot_empty", mem_req_valid, 0);
    mem_resp_valid = 1; mem_resp_data = 16'h1111;
    tick(); #1;
    chk("pri_disp_resp", {disp_resp_valid, fade_resp_valid, disp_resp_data}, {2'b10, 16'h1111});
    mem_resp_valid = 1; mem_resp_data = 16'h2222;
    tick(); #1;
    chk("pri_fade_resp", {disp_resp_valid, fade_resp_valid, fade_resp_data}, {2'b01, 16'h2222});

    // Starvation: wr wins on its 9th waiting cycle
    auto_resp = 1;
    disp_req_valid = 1; disp_req_addr = 20'h00040;
    wr_req_valid = 1; wr_req_addr = 20'h00050; wr_req_wdata = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stv_wait", {disp_req_ready, wr_req_ready}, 2'b10);
      tick();
    end
    #1;
    chk("stv_force", {disp_req_ready, wr_req_ready}, 2'b01);
    tick(); #1;
    chk("stv_resume", {disp_req_ready, wr_req_ready}, 2'b10);
    chk("stv_mem_wr", {mem_req_we, mem_req_addr, mem_req_wdata}, {1'b1, 20'h00050, 16'h1234});
    disp_req_valid = 0; wr_req_valid = 0;
    for (int i = 0; i < 6; i++) tick();
    auto_resp = 0;
    tick();

    // Outstanding limit
    disp_req_valid = 1; disp_req_addr = 20'h00060;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("out_issue", disp_req_ready, 1);
      tick();
    end
    #1;
    chk("out_full", disp_req_ready, 0);
    wr_req_valid = 1; wr_req_addr = 20'h00070; wr_req_wdata = 16'h5555; #1;
    chk("out_wr_ok", wr_req_ready, 1);
    tick(); wr_req_valid = 0;
    mem_resp_valid = 1; mem_resp_data = 16'hD00D; #1;
    chk("out_still_full", disp_req_ready, 0);
    tick(); #1;
    chk("out_freed", disp_req_ready, 1);
    chk("out_resp", {disp_resp_valid, disp_resp_data}, {1'b1, 16'hD00D});
    tick(); #1;
    chk("out_full_again", disp_req_ready, 0);
    disp_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1; mem_resp_data = 16'h0;
      tick();
    end
    tick();

    // Routing order
    disp_req_valid = 1; disp_req_addr = 20'h00100; #1;
    chk("rt_iss0", disp_req_ready, 1);
    tick(); disp_req_valid = 0;
    fade_req_valid = 1; fade_req_we = 0; fade_req_addr = 20'h00200; #1;
    chk("rt_iss1", fade_req_ready, 1);
    tick(); fade_req_valid = 0;
    disp_req_valid = 1; disp_req_addr = 20'h00300; #1;
    chk("rt_iss2", disp_req_ready, 1);
    tick(); disp_req_valid = 0;
    mem_resp_valid = 1; mem_resp_data = 16'hAAAA;
    tick(); #1;
    chk("rt_r0", {disp_resp_valid, fade_resp_valid, disp_resp_data}, {2'b10, 16'hAAAA});
    mem_resp_valid = 1; mem_resp_data = 16'hBBBB;
    tick(); #1;
    chk("rt_r1", {disp_resp_valid, fade_resp_valid, fade_resp_data}, {2'b01, 16'hBBBB});
    mem_resp_valid = 1; mem_resp_data = 16'hCCCC;
    tick(); #1;
    chk("rt_r2", {disp_resp_valid, fade_resp_valid, disp_resp_data}, {2'b10, 16'hCCCC});
    tick(); #1;
    chk("rt_idle", {disp_resp_valid, fade_resp_valid}, 2'b00);

    // Backpressure on the output slot
    mem_req_ready = 0;
    wr_req_valid = 1; wr_req_addr = 20'h12345; wr_req_wdata = 16'hCAFE; #1;
    chk("bp_wr_rdy", wr_req_ready, 1);
    tick(); wr_req_valid = 0;
    disp_req_valid = 1; disp_req_addr = 20'h00400;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, {2'b11, 20'h12345, 16'hCAFE});
      chk("bp_no_rdy", {disp_req_ready, fade_req_ready, wr_req_ready}, 0);
      tick();
    end
    mem_req_ready = 1; #1;
    chk("bp_release_rdy", disp_req_ready, 1);
    tick(); #1;
    chk("bp_next", {mem_req_valid, mem_req_we, mem_req_addr}, {2'b10, 20'h00400});

    // Reset mid-traffic, then an unexpected response
    disp_req_addr = 20'h00500;
    fade_req_valid = 1; fade_req_we = 1; wr_req_valid = 1;
    tick();
    reset = 1; #1;
    chk("mr_rdy", {disp_req_ready, fade_req_ready, wr_req_ready}, 0);
    tick(); #1;
    chk("mr_outs", {mem_req_valid, mem_req_we, mem_req_addr, disp_resp_valid, fade_resp_valid, resp_err}, 0);
    reset = 0; disp_req_valid = 0; fade_req_valid = 0; wr_req_valid = 0;
    tick();
    mem_resp_valid = 1; mem_resp_data = 16'h9999;
    tick(); #1;
    chk("err_set", {resp_err, disp_resp_valid, fade_resp_valid}, 3'b100);
    tick(); #1;
    chk("err_sticky", resp_err, 1);
    reset = 1;
    tick(); #1;
    chk("err_clear", resp_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
